hit_equation_evaluator: RTL and testbench

Consumes the per-frame hit pulses produced by the collision logic (number hits, operand hits, water collision) and turns them into an arithmetic equation the monkey builds by touching objects. Keeps a running accumulator and compares it against the level target. Emits a solved pulse, a saturating score and per-number respawn requests back to the object generators. Sits between the collision controller and the score/level logic in the VGA game top.

---
 rtl/hit_eq_pkg.sv | 16 +
 rtl/equation_alu.sv | 25 ++
 rtl/hit_equation_evaluator.sv | 143 ++++++++++++++
 tb/tb_hit_equation_evaluator.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_eq_pkg.sv
// Shared types and constants for the hit equation evaluator.
package hit_eq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OP,
    WAIT_NUM,
    CHECK,
    SOLVED
  } state_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_PLUS  = 2'b01;
  localparam logic [1:0] OP_MINUS = 2'b10;

endpackage

// File: rtl/equation_alu.sv
// Saturating add/subtract of a zero-extended number value onto the accumulator.
module equation_alu #(
  parameter int unsigned VALUE_W = 4,
  parameter int unsigned ACC_W   = 8
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [VALUE_W-1:0] value,
  input  logic               subtract,
  output logic [ACC_W-1:0]   result
);

  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum;

  always_comb begin
    operand = ACC_W'(value);
    sum     = {1'b0, acc} + {1'b0, operand};
    if (subtract) begin
      result = (operand > acc) ? '0 : acc - operand;
    end else begin
      result = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/hit_equation_evaluator.sv
// Builds an equation from number/operand hits, compares against the level
// target and reports solved pulses, a saturating score and respawn requests.
module hit_equation_evaluator
  import hit_eq_pkg::*;
#(
  parameter int unsigned NUMBERS = 3,
  parameter int unsigned VALUE_W = 4,
  parameter int unsigned ACC_W   = 8,
  parameter int unsigned SCORE_W = 8
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic [NUMBERS-1:0]           SingleHitPulse,
  input  logic [1:0]                   operandHit,
  input  logic                         waterCollision,
  input  logic [NUMBERS*VALUE_W-1:0]   numberValues,
  input  logic [ACC_W-1:0]             target,
  output logic [ACC_W-1:0]             accumulator,
  output logic [1:0]                   pendingOp,
  output logic [NUMBERS-1:0]           respawnReq,
  output logic                         solved,
  output logic [SCORE_W-1:0]           score,
  output logic                         busy
);

  state_t               state, state_d;
  logic [ACC_W-1:0]     acc_d;
  logic [1:0]           op_d;
  logic [NUMBERS-1:0]   resp_d;
  logic                 solved_d;
  logic [SCORE_W-1:0]   score_d;

  logic                 hit_any;
  logic [NUMBERS-1:0]   hit_oh;
  logic [VALUE_W-1:0]   hit_val;
  logic [1:0]           op_hit;
  logic [ACC_W-1:0]     alu_result;

  // Lowest-index number hit wins.
  always_comb begin
    hit_any = 1'b0;
    hit_oh  = '0;
    hit_val = '0;
    for (int i = 0; i < NUMBERS; i++) begin
      if (SingleHitPulse[i] && !hit_any) begin
        hit_any   = 1'b1;
        hit_oh[i] = 1'b1;
        hit_val   = numberValues[i*VALUE_W +: VALUE_W];
      end
    end
  end

  assign op_hit = operandHit[0] ? OP_PLUS : (operandHit[1] ? OP_MINUS : OP_NONE);

  equation_alu #(
    .VALUE_W (VALUE_W),
    .ACC_W   (ACC_W)
  ) u_alu (
    .acc      (accumulator),
    .value    (hit_val),
    .subtract (pendingOp == OP_MINUS),
    .result   (alu_result)
  );

  // Next-state and next-output logic; water overrides everything.
  always_comb begin
    state_d  = state;
    acc_d    = accumulator;
    op_d     = pendingOp;
    resp_d   = '0;
    solved_d = 1'b0;
    score_d  = score;
    if (waterCollision) begin
      state_d = IDLE;
      acc_d   = '0;
      op_d    = OP_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (hit_any) begin
            acc_d   = ACC_W'(hit_val);
            resp_d  = hit_oh;
            state_d = WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (op_hit != OP_NONE) begin
            op_d    = op_hit;
            state_d = WAIT_NUM;
          end
        end
        WAIT_NUM: begin
          if (hit_any) begin
            acc_d   = alu_result;
            resp_d  = hit_oh;
            op_d    = OP_NONE;
            state_d = CHECK;
          end else if (op_hit != OP_NONE) begin
            op_d = op_hit;
          end
        end
        CHECK: begin
          if (accumulator == target) begin
            solved_d = 1'b1;
            if (score != '1) score_d = score + SCORE_W'(1);
            state_d = SOLVED;
          end else begin
            state_d = WAIT_OP;
          end
        end
        SOLVED: begin
          if (startOfFrame) begin
            acc_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state       <= IDLE;
      accumulator <= '0;
      pendingOp   <= OP_NONE;
      respawnReq  <= '0;
      solved      <= 1'b0;
      score       <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      accumulator <= acc_d;
      pendingOp   <= op_d;
      respawnReq  <= resp_d;
      solved      <= solved_d;
      score       <= score_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_hit_equation_evaluator.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_hit_equation_evaluator;

  localparam int unsigned NUMBERS = 3;
  localparam int unsigned VALUE_W = 4;
  localparam int unsigned ACC_W   = 8;
  localparam int unsigned SCORE_W = 8;

  localparam int PH_IDLE  = 0;
  localparam int PH_OP    = 1;
  localparam int PH_NUM   = 2;
  localparam int PH_CHECK = 3;
  localparam int PH_DONE  = 4;

  logic                       clk = 1'b0;
  logic                       resetN;
  logic                       startOfFrame;
  logic [NUMBERS-1:0]         SingleHitPulse;
  logic [1:0]                 operandHit;
  logic                       waterCollision;
  logic [NUMBERS*VALUE_W-1:0] numberValues;
  logic [ACC_W-1:0]           target;
  logic [ACC_W-1:0]           accumulator;
  logic [1:0]                 pendingOp;
  logic [NUMBERS-1:0]         respawnReq;
  logic                       solved;
  logic [SCORE_W-1:0]         score;
  logic                       busy;

  hit_equation_evaluator #(
    .NUMBERS (NUMBERS),
    .VALUE_W (VALUE_W),
    .ACC_W   (ACC_W),
    .SCORE_W (SCORE_W)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .SingleHitPulse (SingleHitPulse),
    .operandHit     (operandHit),
    .waterCollision (waterCollision),
    .numberValues   (numberValues),
    .target         (target),
    .accumulator    (accumulator),
    .pendingOp      (pendingOp),
    .respawnReq     (respawnReq),
    .solved         (solved),
    .score          (score),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state: what the outputs must read after the last edge.
  int m_phase;
  int exp_acc, exp_op, exp_resp, exp_solved, exp_score, exp_busy;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int value_of(input int i);
    return int'(numberValues[i*VALUE_W +: VALUE_W]);
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE;
    exp_acc = 0; exp_op = 0; exp_resp = 0;
    exp_solved = 0; exp_score = 0; exp_busy = 0;
  endtask

  task automatic model_step();
    int idx = -1;
    int v;
    for (int i = 0; i < int'(NUMBERS); i++)
      if (SingleHitPulse[i] && idx < 0) idx = i;
    exp_resp   = 0;
    exp_solved = 0;
    if (waterCollision) begin
      m_phase = PH_IDLE; exp_acc = 0; exp_op = 0;
    end else if (m_phase == PH_IDLE) begin
      if (idx >= 0) begin
        exp_acc = value_of(idx); exp_resp = 1 << idx; m_phase = PH_OP;
      end
    end else if (m_phase == PH_OP) begin
      if (operandHit != 2'b00) begin
        exp_op = operandHit[0] ? 1 : 2; m_phase = PH_NUM;
      end
    end else if (m_phase == PH_NUM) begin
      if (idx >= 0) begin
        v = value_of(idx);
        if (exp_op == 1) exp_acc = (exp_acc + v > 255) ? 255 : exp_acc + v;
        else             exp_acc = (exp_acc - v < 0)   ? 0   : exp_acc - v;
        exp_resp = 1 << idx; exp_op = 0; m_phase = PH_CHECK;
      end else if (operandHit != 2'b00) begin
        exp_op = operandHit[0] ? 1 : 2;
      end
    end else if (m_phase == PH_CHECK) begin
      if (exp_acc == int'(target)) begin
        exp_solved = 1;
        if (exp_score < 255) exp_score++;
        m_phase = PH_DONE;
      end else begin
        m_phase = PH_OP;
      end
    end else begin
      if (startOfFrame) begin
        exp_acc = 0; m_phase = PH_IDLE;
      end
    end
    exp_busy = (m_phase != PH_IDLE) ? 1 : 0;
  endtask

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("accumulator", int'(accumulator), exp_acc);
      check("pendingOp",   int'(pendingOp),   exp_op);
      check("respawnReq",  int'(respawnReq),  exp_resp);
      check("solved",      int'(solved),      exp_solved);
      check("score",       int'(score),       exp_score);
      check("busy",        int'(busy),        exp_busy);
    end
  end

  task automatic cyc(input logic sof, input logic [2:0] h, input logic [1:0] o, input logic w);
    startOfFrame   = sof;
    SingleHitPulse = h;
    operandHit     = o;
    waterCollision = w;
    @(posedge clk);
    model_step();
    @(negedge clk);
    startOfFrame   = 1'b0;
    SingleHitPulse = '0;
    operandHit     = '0;
    waterCollision = 1'b0;
  endtask

  task automatic reset_pulse();
    #2;
    resetN = 1'b1;
    model_reset();
    #1;
    check("rst_acc",   int'(accumulator), 0);
    check("rst_op",    int'(pendingOp),   0);
    check("rst_score", int'(score),       0);
    check("rst_busy",  int'(busy),        0);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b0;
  endtask

  initial begin
    resetN         = 1'b1;
    startOfFrame   = 1'b0;
    SingleHitPulse = '0;
    operandHit     = '0;
    waterCollision = 1'b0;
    numberValues   = {4'd5, 4'd4, 4'd3};
    target         = 8'd7;
    model_reset();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_resp",   int'(respawnReq), 0);
    check("reset_solved", int'(solved),     0);
    resetN = 1'b0;

    // 3 + 4 = 7 solves
    cyc(0, 3'b001, 2'b00, 0);
    check("s1_acc3", int'(accumulator), 3);
    check("s1_resp1", int'(respawnReq), 1);
    cyc(0, 3'b000, 2'b01, 0);
    check("s1_plus", int'(pendingOp), 1);
    cyc(0, 3'b010, 2'b00, 0);
    check("s1_acc7", int'(accumulator), 7);
    check("s1_resp2", int'(respawnReq), 2);
    check("s1_nosolve_yet", int'(solved), 0);
    cyc(0, 3'b000, 2'b00, 0);
    check("s1_solved", int'(solved), 1);
    check("s1_score", int'(score), 1);
    cyc(0, 3'b000, 2'b00, 0);
    check("s1_solved_low", int'(solved), 0);
    cyc(1, 3'b000, 2'b00, 0);
    check("s1_sof_acc", int'(accumulator), 0);

    // 2 - 5 saturates at 0
    numberValues = {4'd0, 4'd5, 4'd2};
    cyc(0, 3'b001, 2'b00, 0);
    cyc(0, 3'b000, 2'b10, 0);
    cyc(0, 3'b010, 2'b00, 0);
    check("s2_acc0", int'(accumulator), 0);
    cyc(0, 3'b000, 2'b00, 0);
    check("s2_nosolve", int'(solved), 0);
    check("s2_busy", int'(busy), 1);

    // lowest index wins
    cyc(0, 3'b000, 2'b00, 1);
    numberValues = {4'd5, 4'd4, 4'd3};
    cyc(0, 3'b110, 2'b00, 0);
    check("s3_resp", int'(respawnReq), 2);
    check("s3_acc", int'(accumulator), 4);

    // last operand wins: 9 - 4 = 5
    cyc(0, 3'b000, 2'b00, 1);
    numberValues = {4'd0, 4'd4, 4'd9};
    cyc(0, 3'b001, 2'b00, 0);
    cyc(0, 3'b000, 2'b01, 0);
    cyc(0, 3'b000, 2'b10, 0);
    check("s4_minus", int'(pendingOp), 2);
    cyc(0, 3'b010, 2'b00, 0);
    check("s4_acc5", int'(accumulator), 5);
    cyc(0, 3'b000, 2'b00, 0);

    // water in WAIT_NUM
    cyc(0, 3'b000, 2'b00, 1);
    numberValues = {4'd0, 4'd4, 4'd6};
    cyc(0, 3'b001, 2'b00, 0);
    cyc(0, 3'b000, 2'b01, 0);
    cyc(0, 3'b000, 2'b00, 1);
    check("s5_acc", int'(accumulator), 0);
    check("s5_op", int'(pendingOp), 0);
    check("s5_busy", int'(busy), 0);
    check("s5_score", int'(score), 1);

    // reset mid-operation
    numberValues = {4'd5, 4'd4, 4'd3};
    cyc(0, 3'b001, 2'b00, 0);
    cyc(0, 3'b000, 2'b01, 0);
    reset_pulse();

    // score saturation
    for (int k = 0; k < 256; k++) begin
      cyc(0, 3'b001, 2'b00, 0);
      cyc(0, 3'b000, 2'b01, 0);
      cyc(0, 3'b010, 2'b00, 0);
      cyc(0, 3'b000, 2'b00, 0);
      cyc(1, 3'b000, 2'b00, 0);
    end
    check("s6_score_sat", int'(score), 255);
    cyc(0, 3'b001, 2'b00, 0);
    cyc(0, 3'b000, 2'b01, 0);
    cyc(0, 3'b010, 2'b00, 0);
    cyc(0, 3'b000, 2'b00, 0);
    check("s6_solved", int'(solved), 1);
    check("s6_score_hold", int'(score), 255);
    cyc(0, 3'b111, 2'b11, 0);
    check("s6_ignore_resp", int'(respawnReq), 0);
    check("s6_ignore_acc", int'(accumulator), 7);
    cyc(1, 3'b000, 2'b00, 0);
    check("s6_sof_acc", int'(accumulator), 0);
    check("s6_sof_busy", int'(busy), 0);

    // random stimulus against the model
    reset_pulse();
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] h;
      logic [1:0] o;
      if (n % 50 == 0) numberValues = 12'($urandom);
      if (n % 37 == 0) target = 8'($urandom_range(0, 15));
      h = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      o = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cyc(($urandom_range(0, 7) == 0), h, o, ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
